// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_pkg
// Brief  : Shared types and address-match helper for the Wishbone decoder.
// Rev    : 1.0
// ============================================================================
package wb_pkg;

  localparam int unsigned c_ADDR_MAX = 64;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    ERR_RESP = 2'd2
  } wb_dec_state_t;

  // Callers zero-extend narrower addresses to c_ADDR_MAX bits.
  function automatic bit wb_addr_match(input logic [c_ADDR_MAX-1:0] addr,
                                       input logic [c_ADDR_MAX-1:0] base,
                                       input logic [c_ADDR_MAX-1:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// ============================================================================
// Module : priority_encoder
// Brief  : Returns the index of the winning request bit plus a valid flag.
// Rev    : 1.0
// ============================================================================
module priority_encoder #(
  parameter int WIDTH             = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b1,
  parameter int IDX_W             = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // The last assignment in each scan wins, so scan direction sets priority.
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    if (LSB_HIGH_PRIORITY) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (i_req[i]) o_idx = IDX_W'(i);
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (i_req[i]) o_idx = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_decoder.sv
`default_nettype none
// ============================================================================
// Module : wb_decoder
// Brief  : Wishbone B4 classic 1-to-PORTS address decoder with error/timeout.
// Rev    : 1.0
// ============================================================================
module wb_decoder
  import wb_pkg::*;
#(
  parameter int                          PORTS      = 4,
  parameter int                          ADDR_WIDTH = 32,
  parameter int                          DATA_WIDTH = 32,
  parameter int                          SEL_WIDTH  = DATA_WIDTH / 8,
  parameter logic [PORTS*ADDR_WIDTH-1:0] BASE_ADDR  = {32'h1000_0000, 32'h0002_0000,
                                                       32'h0001_0000, 32'h0000_0000},
  parameter logic [PORTS*ADDR_WIDTH-1:0] ADDR_MASK  = {32'hF000_0000, 32'hFFFF_0000,
                                                       32'hFFFF_0000, 32'hFFFF_0000},
  parameter int                          TIMEOUT    = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_WIDTH-1:0]       wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]       wbm_dat_i,
  output logic [DATA_WIDTH-1:0]       wbm_dat_o,
  input  logic                        wbm_we_i,
  input  logic [SEL_WIDTH-1:0]        wbm_sel_i,
  input  logic                        wbm_stb_i,
  input  logic                        wbm_cyc_i,
  output logic                        wbm_ack_o,
  output logic                        wbm_err_o,
  output logic                        wbm_rty_o,
  output logic [ADDR_WIDTH-1:0]       wbs_adr_o,
  output logic [DATA_WIDTH-1:0]       wbs_dat_o,
  output logic                        wbs_we_o,
  output logic [SEL_WIDTH-1:0]        wbs_sel_o,
  output logic [PORTS-1:0]            wbs_cyc_o,
  output logic [PORTS-1:0]            wbs_stb_o,
  input  logic [PORTS*DATA_WIDTH-1:0] wbs_dat_i,
  input  logic [PORTS-1:0]            wbs_ack_i,
  input  logic [PORTS-1:0]            wbs_err_i,
  input  logic [PORTS-1:0]            wbs_rty_i
);

  localparam int                c_IDX_W   = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam int                c_TO_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);

  wb_dec_state_t      r_state;
  wb_dec_state_t      w_state_nxt;
  logic [c_IDX_W-1:0] r_sel_idx;
  logic [c_IDX_W-1:0] w_sel_idx_nxt;
  logic [c_TO_W-1:0]  r_to_cnt;
  logic [c_TO_W-1:0]  w_to_cnt_nxt;
  logic [PORTS-1:0]   w_match;
  logic               w_hit;
  logic [c_IDX_W-1:0] w_hit_idx;
  logic               w_s_ack;
  logic               w_s_err;
  logic               w_s_rty;

  assign wbs_adr_o = wbm_adr_i;
  assign wbs_dat_o = wbm_dat_i;
  assign wbs_we_o  = wbm_we_i;
  assign wbs_sel_o = wbm_sel_i;

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_match
    assign w_match[gi] = wb_addr_match(c_ADDR_MAX'(wbm_adr_i),
                                       c_ADDR_MAX'(BASE_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH]),
                                       c_ADDR_MAX'(ADDR_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]));
  end

  priority_encoder #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (1'b1),
    .IDX_W             (c_IDX_W)
  ) u_match_enc (
    .i_req   (w_match),
    .o_valid (w_hit),
    .o_idx   (w_hit_idx)
  );

  assign w_s_ack = wbs_ack_i[r_sel_idx];
  assign w_s_err = wbs_err_i[r_sel_idx];
  assign w_s_rty = wbs_rty_i[r_sel_idx];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_sel_idx <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_sel_idx <= w_sel_idx_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sel_idx_nxt = r_sel_idx;
    w_to_cnt_nxt  = r_to_cnt;
    wbs_cyc_o     = '0;
    wbs_stb_o     = '0;
    wbm_ack_o     = 1'b0;
    wbm_err_o     = 1'b0;
    wbm_rty_o     = 1'b0;
    wbm_dat_o     = '0;

    case (r_state)
      IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (w_hit) begin
            w_state_nxt   = ACTIVE;
            w_sel_idx_nxt = w_hit_idx;
            w_to_cnt_nxt  = '0;
          end else begin
            w_state_nxt = ERR_RESP;
          end
        end
      end

      ACTIVE: begin
        wbs_cyc_o[r_sel_idx] = wbm_cyc_i;
        wbs_stb_o[r_sel_idx] = wbm_stb_i;
        wbm_dat_o            = wbs_dat_i[r_sel_idx*DATA_WIDTH +: DATA_WIDTH];
        // Abort takes precedence; a response in the expiry cycle beats the timeout.
        if (!wbm_cyc_i) begin
          w_state_nxt = IDLE;
        end else if (w_s_ack || w_s_err || w_s_rty) begin
          wbm_err_o   = w_s_err;
          wbm_rty_o   = !w_s_err && w_s_rty;
          wbm_ack_o   = !w_s_err && !w_s_rty;
          w_state_nxt = IDLE;
        end else if (TIMEOUT > 0) begin
          if (r_to_cnt == c_TO_LAST) begin
            w_state_nxt = ERR_RESP;
          end else begin
            w_to_cnt_nxt = r_to_cnt + c_TO_ONE;
          end
        end
      end

      ERR_RESP: begin
        wbm_err_o   = wbm_cyc_i;
        w_state_nxt = IDLE;
      end

      default: w_state_nxt = IDLE;
    endcase
  end

endmodule
`default_nettype wire
